sort_datapath: RTL and testbench
================================

# sort_datapath

Datapath counterpart of the sort control unit. It holds the element memory, the index counter and the low/high/temp compare registers. It executes the control unit's enable and write-select strobes and returns the `gte`, `counted` and `sorted` status flags that steer the control unit's state machine. Values are loaded serially from `data_in` and bubble-sorted in place into ascending unsigned order. After sorting they are read back through a side read port.

## Interface
- `WIDTH`, 8, element width in bits
- `DEPTH`, 8, number of elements; must be a power of two and at least 2
- `AW`, 3, index width, equal to log2(`DEPTH`)

Ports:
- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-low reset
- `data_in` in `WIDTH`: load value
- `mem_en` in 1: memory write strobe
- `writemux` in 2: write source and target select
- `low_en` in 1: load `low_reg` from `mem[idx]`
- `high_en` in 1: load `high_reg` from `mem[idx+1]`
- `temp_en` in 1: load `temp_reg` from `low_reg`
- `stat_en` in 1: advance the compare index and update pass status
- `rd_addr` in `AW`: readback address
- `rd_data` out `WIDTH`: combinational `mem[rd_addr]`
- `gte` out 1: combinational, `low_reg >= high_reg` (unsigned)
- `counted` out 1: combinational, index is at the last position for the current phase
- `sorted` out 1: registered, last completed pass made no swaps

## Operation
- State:
  - `phase` is LOAD or SORT.
  - `idx` is `AW` bits.
  - Registers: `low_reg`, `high_reg`, `temp_reg`, `swap_flag`, `sorted`, and `mem[DEPTH]`.
- Write selection when `mem_en` is high:
  - `writemux` 00 (LOAD): `mem[idx] <= data_in`.
  - 01 (HIGH): `mem[idx] <= high_reg`, and `swap_flag <= 1`.
  - 10 (LOW): `mem[idx+1] <= low_reg`.
  - 11 (TEMP): `mem[idx+1] <= temp_reg`.
- A swap is the sequence `temp_en`, then `mem_en` with HIGH, then `mem_en` with TEMP.
- LOAD phase:
  - `mem_en` with 00 writes the value and increments `idx`.
  - The write at `idx = DEPTH-1` wraps `idx` to 0 and sets `phase` to SORT.
  - `stat_en` is ignored.
- SORT phase:
  - `mem_en` with 00 writes `mem[idx]` and does not increment `idx`.
  - `stat_en` with `idx < DEPTH-2` increments `idx`.
  - `stat_en` with `idx = DEPTH-2` ends the pass: `sorted <= ~swap_flag`, `swap_flag <= 0`, `idx <= 0`.
- `counted`:
  - `idx == DEPTH-1` in LOAD.
  - `idx == DEPTH-2` in SORT.
- Boundary: in SORT, if `idx = DEPTH-1`, writes with 10 or 11 are suppressed and `high_en` loads 0. This state is unreachable in normal operation.
- Simultaneous events:
  - A write always uses the pre-increment `idx`.
  - `low_en`, `high_en` and `temp_en` may coincide. `temp_reg` takes the old `low_reg`.
  - On a pass end coinciding with a HIGH write, `sorted` uses `swap_flag | 1`, i.e. `sorted` becomes 0.
- Once `sorted` = 1 it holds until reset. Re-running requires reset.

## Timing
- All registers update on the rising edge of `clk`.
- Async reset (`rst` = 0) immediately forces:
  - `idx` = 0, `phase` = LOAD;
  - `low_reg`, `high_reg`, `temp_reg` = 0;
  - `swap_flag` = 0, `sorted` = 0;
  - all `mem` entries = 0.
- Output values during and after reset:
  - `gte` = 1, since 0 >= 0.
  - `counted` = 0.
  - `rd_data` = 0.
- Reset taken mid-sort discards all data; the next cycle expects a LOAD write.
- `gte` is valid the cycle after the last `low_en`/`high_en` edge.
- `counted` is valid the cycle after the `idx` update.
- `sorted` is valid the cycle after the pass-ending `stat_en`.
- Zero-cycle combinational paths: `rd_addr` to `rd_data`. No enable input reaches an output combinationally.

## Structure
- Package `sort_pkg` holds:
  - default `WIDTH`/`DEPTH`;
  - `writemux` encodings `WM_LOAD`, `WM_HIGH`, `WM_LOW`, `WM_TEMP`;
  - the `phase` enum.
- The CU shares `sort_pkg`.
- One sub-module, `sort_regfile`: `DEPTH`×`WIDTH` array with:
  - async clear;
  - one write port;
  - three combinational read ports (`idx`, `idx+1`, `rd_addr`).
- Index, phase, compare registers and status logic live in the top module.

## Test plan
- Load 5,3,7,1,8,2,6,4. `counted` rises after the 7th write and `phase` becomes SORT after the 8th write; then `rd_addr` 0..7 returns 5,3,7,1,8,2,6,4.
- Drive full CU-style swap passes on that data until `sorted` = 1. Readback is 1..8, and `sorted` remains 0 after every pass that swapped.
- Load the already ascending 1..8 and run one pass with no swaps. `sorted` = 1 one cycle after the 7th `stat_en`.
- Load all entries as 9. `gte` = 1 on every compare; a pass with no HIGH writes gives `sorted` = 1.
- Assert reset after 3 SORT-phase `stat_en`. Immediately `sorted` = 0, `counted` = 0 and `rd_data` = 0; a reload then works normally.
- Force `idx` = 7 in SORT and issue `mem_en` with `writemux` 11. No memory entry changes.

Source files
------------

// File: rtl/sort_pkg.sv
// sort_pkg
//   Shared definitions for the sort datapath and its control unit:
//   default element width/depth, write-select encodings and the phase enum.
package sort_pkg;

    localparam int SORT_WIDTH = 8;
    localparam int SORT_DEPTH = 8;

    // writemux encodings
    localparam logic [1:0] WM_LOAD = 2'b00;  // mem[idx]   <= data_in
    localparam logic [1:0] WM_HIGH = 2'b01;  // mem[idx]   <= high_reg
    localparam logic [1:0] WM_LOW  = 2'b10;  // mem[idx+1] <= low_reg
    localparam logic [1:0] WM_TEMP = 2'b11;  // mem[idx+1] <= temp_reg

    typedef enum logic {
        PH_LOAD = 1'b0,
        PH_SORT = 1'b1
    } phase_t;

endpackage

// File: rtl/sort_regfile.sv
// sort_regfile
//   DEPTH x WIDTH element store with asynchronous clear, one synchronous
//   write port and three combinational read ports.
//
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low clear of every entry
//   wr_en     in   write strobe
//   wr_addr   in   write address
//   wr_data   in   write data
//   rd0_addr  in   read port 0 address  (compare index)
//   rd0_data  out  mem[rd0_addr]
//   rd1_addr  in   read port 1 address  (compare index + 1)
//   rd1_data  out  mem[rd1_addr]
//   rd2_addr  in   read port 2 address  (external readback)
//   rd2_data  out  mem[rd2_addr]
module sort_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd0_addr,
    output logic [WIDTH-1:0] rd0_data,
    input  logic [AW-1:0]    rd1_addr,
    output logic [WIDTH-1:0] rd1_data,
    input  logic [AW-1:0]    rd2_addr,
    output logic [WIDTH-1:0] rd2_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd0_data = mem[rd0_addr];
    assign rd1_data = mem[rd1_addr];
    assign rd2_data = mem[rd2_addr];

endmodule

// File: rtl/sort_datapath.sv
// sort_datapath
//   Datapath half of the bubble sorter. Holds the element store, the compare
//   index, the low/high/temp registers and the pass status, and executes the
//   strobes issued by the sort control unit.
//
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   data_in   in   serial load value
//   mem_en    in   memory write strobe
//   writemux  in   write source/target select (WM_* in sort_pkg)
//   low_en    in   low_reg  <= mem[idx]
//   high_en   in   high_reg <= mem[idx+1]
//   temp_en   in   temp_reg <= low_reg
//   stat_en   in   advance compare index / close the pass
//   rd_addr   in   readback address
//   rd_data   out  mem[rd_addr], combinational
//   gte       out  low_reg >= high_reg (unsigned), combinational
//   counted   out  index at last position of the current phase
//   sorted    out  last completed pass made no swaps (sticky until reset)
module sort_datapath
    import sort_pkg::*;
#(
    parameter int WIDTH = SORT_WIDTH,
    parameter int DEPTH = SORT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             mem_en,
    input  logic [1:0]       writemux,
    input  logic             low_en,
    input  logic             high_en,
    input  logic             temp_en,
    input  logic             stat_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             gte,
    output logic             counted,
    output logic             sorted
);

    localparam logic [AW-1:0] IDX_LAST    = AW'(DEPTH - 1);
    localparam logic [AW-1:0] IDX_PENULT  = AW'(DEPTH - 2);

    phase_t           phase;
    logic [AW-1:0]    idx;
    logic [AW-1:0]    idx_p1;
    logic [WIDTH-1:0] low_reg;
    logic [WIDTH-1:0] high_reg;
    logic [WIDTH-1:0] temp_reg;
    logic             swap_flag;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] mem_lo;
    logic [WIDTH-1:0] mem_hi;

    logic             at_last;
    logic             at_penult;
    logic             edge_block;
    logic             hi_write;
    logic             load_write;
    logic             pass_end;

    assign idx_p1    = idx + 1'b1;
    assign at_last   = (idx == IDX_LAST);
    assign at_penult = (idx == IDX_PENULT);

    // idx+1 would wrap onto mem[0] here; keep the neighbour-side accesses inert.
    assign edge_block = (phase == PH_SORT) && at_last;

    assign hi_write   = mem_en && (writemux == WM_HIGH);
    assign load_write = mem_en && (writemux == WM_LOAD);
    assign pass_end   = stat_en && (phase == PH_SORT) && at_penult;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = idx;
        wr_data = data_in;
        if (mem_en) begin
            case (writemux)
                WM_LOAD: begin
                    wr_en   = 1'b1;
                    wr_data = data_in;
                end
                WM_HIGH: begin
                    wr_en   = 1'b1;
                    wr_data = high_reg;
                end
                WM_LOW: begin
                    wr_en   = !edge_block;
                    wr_addr = idx_p1;
                    wr_data = low_reg;
                end
                default: begin
                    wr_en   = !edge_block;
                    wr_addr = idx_p1;
                    wr_data = temp_reg;
                end
            endcase
        end
    end

    sort_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd0_addr (idx),
        .rd0_data (mem_lo),
        .rd1_addr (idx_p1),
        .rd1_data (mem_hi),
        .rd2_addr (rd_addr),
        .rd2_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase     <= PH_LOAD;
            idx       <= '0;
            low_reg   <= '0;
            high_reg  <= '0;
            temp_reg  <= '0;
            swap_flag <= 1'b0;
            sorted    <= 1'b0;
        end else begin
            if (low_en) begin
                low_reg <= mem_lo;
            end
            if (high_en) begin
                high_reg <= edge_block ? '0 : mem_hi;
            end
            // Non-blocking read of low_reg gives temp the pre-update value.
            if (temp_en) begin
                temp_reg <= low_reg;
            end

            case (phase)
                PH_LOAD: begin
                    if (load_write) begin
                        if (at_last) begin
                            idx   <= '0;
                            phase <= PH_SORT;
                        end else begin
                            idx <= idx_p1;
                        end
                    end
                end
                default: begin
                    if (stat_en) begin
                        if (at_penult) begin
                            idx <= '0;
                        end else if (idx < IDX_PENULT) begin
                            idx <= idx_p1;
                        end
                    end
                end
            endcase

            if (pass_end) begin
                swap_flag <= 1'b0;
            end else if (hi_write) begin
                swap_flag <= 1'b1;
            end

            // A HIGH write on the closing cycle still counts as a swap.
            if (pass_end && !sorted) begin
                sorted <= !(swap_flag || hi_write);
            end
        end
    end

    assign gte     = (low_reg >= high_reg);
    assign counted = (phase == PH_LOAD) ? at_last : at_penult;

endmodule

// File: tb/tb_sort_datapath.sv
module tb_sort_datapath;
    import sort_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             mem_en = 1'b0;
    logic [1:0]       writemux = WM_LOAD;
    logic             low_en = 1'b0;
    logic             high_en = 1'b0;
    logic             temp_en = 1'b0;
    logic             stat_en = 1'b0;
    logic [AW-1:0]    rd_addr = '0;
    logic [WIDTH-1:0] rd_data;
    logic             gte;
    logic             counted;
    logic             sorted;

    int n_vec = 0;
    int n_err = 0;

    int model [DEPTH];
    bit model_sorted;

    always #5 clk = ~clk;

    sort_datapath #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .mem_en   (mem_en),
        .writemux (writemux),
        .low_en   (low_en),
        .high_en  (high_en),
        .temp_en  (temp_en),
        .stat_en  (stat_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .gte      (gte),
        .counted  (counted),
        .sorted   (sorted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = 0;
        model_sorted = 1'b0;
    endtask

    task automatic load_vals(input int v [DEPTH]);
        for (int k = 0; k < DEPTH; k++) begin
            data_in  = WIDTH'(v[k]);
            writemux = WM_LOAD;
            mem_en   = 1'b1;
            step();
            mem_en   = 1'b0;
            model[k] = v[k];
            check($sformatf("counted_load%0d", k), counted, (k == DEPTH - 2));
        end
    endtask

    task automatic readback(input string tag, input int exp [DEPTH]);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            #1;
            check($sformatf("%s_rd%0d", tag, a), rd_data, exp[a]);
        end
    endtask

    // One control-unit style pass: compare every neighbour pair and swap
    // when the lower slot holds the larger value.
    task automatic run_pass();
        bit swapped;
        int t;
        swapped = 1'b0;
        for (int i = 0; i <= DEPTH - 2; i++) begin
            check($sformatf("counted_pos%0d", i), counted, (i == DEPTH - 2));
            low_en  = 1'b1;
            high_en = 1'b1;
            step();
            low_en  = 1'b0;
            high_en = 1'b0;
            check($sformatf("gte_pos%0d", i), gte, (model[i] >= model[i+1]));
            if (model[i] > model[i+1]) begin
                temp_en = 1'b1;
                step();
                temp_en  = 1'b0;
                mem_en   = 1'b1;
                writemux = WM_HIGH;
                step();
                writemux = WM_TEMP;
                step();
                mem_en   = 1'b0;
                t          = model[i];
                model[i]   = model[i+1];
                model[i+1] = t;
                swapped    = 1'b1;
            end
            stat_en = 1'b1;
            step();
            stat_en = 1'b0;
            if (i == DEPTH - 2 && !swapped) model_sorted = 1'b1;
            check($sformatf("sorted_pos%0d", i), sorted, model_sorted);
        end
    endtask

    task automatic sort_all();
        int passes;
        passes = 0;
        while (!model_sorted && passes < DEPTH + 2) begin
            run_pass();
            passes++;
        end
    endtask

    task automatic expect_ascending(input int v [DEPTH], output int e [DEPTH]);
        int q[$];
        q = {};
        for (int i = 0; i < DEPTH; i++) q.push_back(v[i]);
        q.sort();
        for (int i = 0; i < DEPTH; i++) e[i] = q[i];
    endtask

    initial begin
        int v_test [DEPTH];
        int v_asc  [DEPTH];
        int v_nine [DEPTH];
        int v_edge [DEPTH];
        int e_edge [DEPTH];
        int v_rnd  [DEPTH];
        int e_rnd  [DEPTH];

        v_test = '{5, 3, 7, 1, 8, 2, 6, 4};
        v_asc  = '{1, 2, 3, 4, 5, 6, 7, 8};
        v_nine = '{9, 9, 9, 9, 9, 9, 9, 9};
        v_edge = '{10, 200, 30, 40, 50, 60, 70, 80};
        e_edge = '{10, 200, 30, 40, 50, 60, 70, 0};

        // Reset values
        #12;
        check("rst_gte", gte, 1);
        check("rst_counted", counted, 0);
        check("rst_sorted", sorted, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b1;
        step();

        // Reference load and full sort
        do_reset();
        load_vals(v_test);
        readback("loaded", v_test);
        sort_all();
        check("sort1_done", sorted, 1);
        readback("sorted1", v_asc);

        // Already ascending: single pass, no swaps
        do_reset();
        load_vals(v_asc);
        run_pass();
        check("asc_sorted", sorted, 1);
        readback("asc", v_asc);

        // All equal: gte always 1, no swaps
        do_reset();
        load_vals(v_nine);
        run_pass();
        check("nine_sorted", sorted, 1);
        readback("nine", v_nine);

        // Forced idx = DEPTH-1 in SORT: neighbour writes suppressed, high_en loads 0
        do_reset();
        load_vals(v_edge);
        low_en  = 1'b1;
        high_en = 1'b1;
        step();
        low_en  = 1'b0;
        high_en = 1'b0;
        check("edge_gte0", gte, 0);
        stat_en = 1'b1;
        step();
        stat_en = 1'b0;
        low_en  = 1'b1;
        step();
        low_en  = 1'b0;
        temp_en = 1'b1;
        step();
        temp_en = 1'b0;
        force dut.idx = 3'd7;
        #1;
        check("edge_counted", counted, 0);
        high_en = 1'b1;
        step();
        high_en = 1'b0;
        mem_en   = 1'b1;
        writemux = WM_HIGH;
        step();
        writemux = WM_TEMP;
        step();
        writemux = WM_LOW;
        step();
        mem_en = 1'b0;
        release dut.idx;
        readback("edge", e_edge);

        // Async reset mid-sort after a completed pass
        do_reset();
        load_vals(v_asc);
        run_pass();
        for (int k = 0; k < 3; k++) begin
            stat_en = 1'b1;
            step();
        end
        stat_en = 1'b0;
        check("pre_rst_gte", gte, 0);
        rd_addr = AW'(DEPTH - 1);
        rst = 1'b0;
        #1;
        check("mid_rst_sorted", sorted, 0);
        check("mid_rst_counted", counted, 0);
        check("mid_rst_rd_data", rd_data, 0);
        check("mid_rst_gte", gte, 1);
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = 0;
        model_sorted = 1'b0;
        step();
        load_vals(v_test);
        sort_all();
        readback("reload", v_asc);

        // Async reset during LOAD with counted high
        do_reset();
        for (int k = 0; k < DEPTH - 1; k++) begin
            data_in  = WIDTH'(k + 20);
            writemux = WM_LOAD;
            mem_en   = 1'b1;
            step();
        end
        mem_en = 1'b0;
        check("load_counted_hi", counted, 1);
        rst = 1'b0;
        #1;
        check("load_rst_counted", counted, 0);
        rst = 1'b1;
        step();

        // Randomised loads
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < DEPTH; i++) begin
                v_rnd[i] = (r == 3) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            end
            load_vals(v_rnd);
            sort_all();
            check($sformatf("rnd%0d_sorted", r), sorted, 1);
            expect_ascending(v_rnd, e_rnd);
            readback($sformatf("rnd%0d", r), e_rnd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
